// File: rtl/cpu_pkg.sv
// Shared datapath constants for the MIPS core.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h0040_0030;

endpackage

// File: rtl/mux_n.sv
// Generic N-way binary-select mux over a flattened input bus.
// It flags out-of-range select codes instead of reporting them.
module mux_n #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    illegal_o
);

  // An illegal code matches no channel, so the output falls back to zero.
  always_comb begin
    data_o    = '0;
    illegal_o = 1'b1;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o    = in_data_i[k*WIDTH +: WIDTH];
        illegal_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_mux_reg.sv
// Next-PC source stage: selects one of NUM_IN candidates into a PC register
// with stall, flush, previous-value capture and sticky select-error flag.
module pc_mux_reg
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH     = XLEN,
  parameter int unsigned NUM_IN    = 4,
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
  localparam int unsigned SEL_W    = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    load_en,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        out,
  output logic [WIDTH-1:0]        out_prev,
  output logic                    out_valid,
  output logic                    sel_err
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VEC);

  logic [WIDTH-1:0] mux_data;
  logic             mux_illegal;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  mux_n #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN)
  ) u_mux (
    .in_data_i(in_data),
    .sel_i    (sel),
    .data_o   (mux_data),
    .illegal_o(mux_illegal)
  );

  // Flush outranks load; an illegal load only raises the error and never
  // disturbs the PC. Set beats clear when both land on the same edge.
  always_comb begin
    out_d   = out_q;
    prev_d  = prev_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (flush) begin
      out_d   = RST_V;
      prev_d  = out_q;
      valid_d = 1'b1;
    end else if (load_en && !mux_illegal) begin
      out_d   = mux_data;
      prev_d  = out_q;
      valid_d = 1'b1;
    end
    if (load_en && !flush && mux_illegal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= RST_V;
      prev_q  <= RST_V;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out       = out_q;
  assign out_prev  = prev_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_pc_mux_reg.sv
// Directed bench for pc_mux_reg: a 4-input instance for load/stall/flush
// and a 3-input instance that can see illegal select codes.
module tb_pc_mux_reg;

  localparam logic [31:0] RV = 32'h0040_0030;

  logic        clk;
  logic        rst_n;
  logic [127:0] in4;
  logic [1:0]  sel4;
  logic        load4, flush4, clr4;
  logic [31:0] out4, prev4;
  logic        valid4, err4;
  logic [95:0] in3;
  logic [1:0]  sel3;
  logic        load3, flush3, clr3;
  logic [31:0] out3, prev3;
  logic        valid3, err3;

  int testsRun = 0;
  int testsFailed = 0;

  pc_mux_reg #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(in4), .sel(sel4), .load_en(load4),
    .flush(flush4), .err_clr(clr4), .out(out4), .out_prev(prev4),
    .out_valid(valid4), .sel_err(err4)
  );

  pc_mux_reg #(.WIDTH(32), .NUM_IN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(in3), .sel(sel3), .load_en(load3),
    .flush(flush3), .err_clr(clr3), .out(out3), .out_prev(prev3),
    .out_valid(valid3), .sel_err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in4 = '0; sel4 = '0; load4 = 0; flush4 = 0; clr4 = 0;
    in3 = '0; sel3 = '0; load3 = 0; flush3 = 0; clr3 = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_out_in_reset", out4, RV);
    checkOutput("rst_valid_in_reset", 32'(valid4), 32'd0);
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("rst_out", out4, RV);
    checkOutput("rst_prev", prev4, RV);
    checkOutput("rst_valid", 32'(valid4), 32'd0);
    checkOutput("rst_err", 32'(err4), 32'd0);
    checkOutput("rst_valid3", 32'(valid3), 32'd0);

    in4 = {32'h0040_0300, 32'h0040_0100, 32'h0040_0200, 32'h0000_00A0};
    sel4 = 2'd2; load4 = 1;
    applyStimulus();
    checkOutput("load_out", out4, 32'h0040_0100);
    checkOutput("load_prev", prev4, RV);
    checkOutput("load_valid", 32'(valid4), 32'd1);

    load4 = 0;
    for (int i = 0; i < 3; i++) begin
      sel4 = 2'(i);
      in4 = {4{32'hDEAD_0000 + 32'(i)}};
      applyStimulus();
      checkOutput("stall_out", out4, 32'h0040_0100);
      checkOutput("stall_prev", prev4, RV);
    end
    in4 = {32'h0040_0300, 32'h0040_0100, 32'h0040_0200, 32'h0000_00A0};

    sel4 = 2'd1; load4 = 1;
    applyStimulus();
    checkOutput("load1_out", out4, 32'h0040_0200);
    checkOutput("load1_prev", prev4, 32'h0040_0100);
    flush4 = 1;
    applyStimulus();
    checkOutput("flush_out", out4, RV);
    checkOutput("flush_prev", prev4, 32'h0040_0200);
    checkOutput("flush_valid", 32'(valid4), 32'd1);
    flush4 = 0; sel4 = 2'd3;
    applyStimulus();
    checkOutput("load3_out", out4, 32'h0040_0300);
    checkOutput("load3_prev", prev4, RV);
    applyStimulus();
    checkOutput("same_val_out", out4, 32'h0040_0300);
    checkOutput("same_val_prev", prev4, 32'h0040_0300);
    checkOutput("err4_never", 32'(err4), 32'd0);

    in3 = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    sel3 = 2'd1; load3 = 1;
    applyStimulus();
    checkOutput("u3_load_out", out3, 32'h0000_2000);
    checkOutput("u3_load_err", 32'(err3), 32'd0);
    sel3 = 2'd3;
    applyStimulus();
    checkOutput("illegal_out_held", out3, 32'h0000_2000);
    checkOutput("illegal_prev_held", prev3, RV);
    checkOutput("illegal_err_set", 32'(err3), 32'd1);
    sel3 = 2'd0;
    applyStimulus();
    checkOutput("legal_after_out", out3, 32'h0000_1000);
    checkOutput("err_sticky", 32'(err3), 32'd1);
    sel3 = 2'd3; clr3 = 1;
    applyStimulus();
    checkOutput("set_beats_clr", 32'(err3), 32'd1);
    checkOutput("set_clr_out", out3, 32'h0000_1000);
    sel3 = 2'd2;
    applyStimulus();
    checkOutput("clr_err", 32'(err3), 32'd0);
    checkOutput("clr_out", out3, 32'h0000_3000);
    clr3 = 0; sel3 = 2'd3; load3 = 0;
    applyStimulus();
    checkOutput("illegal_stall_err", 32'(err3), 32'd0);
    flush3 = 1; load3 = 1;
    applyStimulus();
    checkOutput("illegal_flush_err", 32'(err3), 32'd0);
    checkOutput("illegal_flush_out", out3, RV);
    checkOutput("illegal_flush_prev", prev3, 32'h0000_3000);
    flush3 = 0;
    applyStimulus();
    checkOutput("err_reset_pre", 32'(err3), 32'd1);
    load3 = 0; load4 = 0;

    applyStimulus();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out", out4, RV);
    checkOutput("midrst_prev", prev4, RV);
    checkOutput("midrst_valid", 32'(valid4), 32'd0);
    checkOutput("midrst_err3", 32'(err3), 32'd0);
    checkOutput("midrst_valid3", 32'(valid3), 32'd0);
    applyStimulus();
    rst_n = 1'b1;
    sel4 = 2'd0; load4 = 1;
    applyStimulus();
    checkOutput("post_rst_out", out4, 32'h0000_00A0);
    checkOutput("post_rst_prev", prev4, RV);
    checkOutput("post_rst_valid", 32'(valid4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pc_mux_reg.md
# pc_mux_reg

Parametrised N-way selector with a registered output, reset vector, stall and flush control, and sticky select-error reporting. It is the next-generation program-counter source stage of the MIPS datapath. It chooses the next PC from N candidate buses: sequential, branch, jump, exception and similar. It holds the value in a register that resets to a defined vector and reports illegal select codes in hardware.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of input channels; legal range 2..16.
- RESET_VEC, 32'h0040_0030, value loaded on reset and on flush; truncated to WIDTH.
- SEL_W (localparam), $clog2(NUM_IN), width of the select code.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  NUM_IN*WIDTH  flattened candidates; channel k is bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  binary channel select; legal codes are 0..NUM_IN-1.
- load_en  in  1  1 = capture the selected channel; 0 = stall and hold.
- flush  in  1  1 = load RESET_VEC regardless of other inputs.
- err_clr  in  1  clears sel_err.
- out  out  WIDTH  registered selected value (current PC).
- out_prev  out  WIDTH  value out held before its most recent update (EPC source).
- out_valid  out  1  0 from reset until the first load or flush, then 1.
- sel_err  out  1  sticky flag; an illegal sel was presented while load_en=1.

## Operation
- Reset, asynchronous on rst_n low: out=RESET_VEC, out_prev=RESET_VEC, out_valid=0, sel_err=0. All four are held while rst_n is low.
- Per-edge priority, highest first:
  - flush=1: out<=RESET_VEC, out_prev<=out, out_valid<=1; sel and load_en are ignored.
  - load_en=1 with sel<NUM_IN: out<=channel[sel], out_prev<=out, out_valid<=1.
  - load_en=1 with sel>=NUM_IN: out, out_prev and out_valid hold; sel_err<=1.
  - load_en=0: all data state holds (stall).
- sel_err update:
  - Set by an illegal select taken while load_en=1 and flush=0.
  - Cleared by err_clr=1.
  - If set and clear occur on the same edge, set wins.
  - An illegal sel while load_en=0 or flush=1 does not set the flag.
- out_prev updates only when out is written. It updates even when the new value equals the old one.
- Selection is pure binary decode; no one-hot encoding or priority between channels.
- Width rule: no arithmetic; values pass through unmodified at WIDTH bits.

## Timing
- Latency: one cycle from sel/in_data/load_en sampled at edge t to out valid after edge t.
- Outputs are registered; no combinational path from any input to any output.
- A flush asserted in the same cycle as an illegal sel takes effect and leaves sel_err unchanged.
- rst_n assertion mid-stall or mid-flush forces the reset values immediately, without waiting for a clock edge.
- Release of rst_n must be synchronous to clk; synchronisation is external to this block.
- First edge after reset release with load_en=1 loads normally.

## Structure
- Shared package cpu_pkg holds:
  - the constant PC_RESET_VEC = 32'h0040_0030 (RESET_VEC default references it);
  - the XLEN = 32 width constant.
- Sub-module mux_n: parametrised (WIDTH, NUM_IN) combinational N-way mux with a flattened input bus. It emits an illegal-select flag rather than a simulation message. pc_mux_reg instantiates one mux_n and wraps it with the register, priority and error logic.
- mux_n is reusable for the ALU-source and writeback selectors.

## Test plan
- Reset: rst_n low then high, no loads -> out=0x00400030, out_prev=0x00400030, out_valid=0, sel_err=0.
- Load: NUM_IN=4, in_data channel 2=0x0040_0100, sel=2, load_en=1 for one edge -> out=0x0040_0100, out_prev=0x0040_0030, out_valid=1.
- Stall: load_en=0 for 3 cycles while sel and in_data change -> out and out_prev unchanged throughout.
- Illegal select: NUM_IN=3, sel=3, load_en=1 -> out held, sel_err=1 and still 1 after sel returns legal. Next, err_clr=1 together with sel=3, load_en=1 -> sel_err remains 1. Then err_clr=1 with a legal sel -> sel_err=0.
- Flush: out=0x0040_0200, flush=1 with load_en=1, sel=1 -> out=0x0040_0030, out_prev=0x0040_0200.
- Reset mid-operation: pull rst_n low between edges during a stall -> out=0x00400030 and out_valid=0 immediately, before the next clk edge.
